icache_refill_engine: RTL

Memory-side refill engine for the instruction cache: on a miss it issues one block read to memory and collects the returned 32-bit words. It packs them in pairs and drives the cache's line-update interface, which is the `cache_update_type` bundle of update, w1_update, w2_update and addr_update. It is the producer end of that interface and sits between the I-cache miss logic and the memory/bus port.

---
 rtl/icache_refill_engine.sv | 126 ++++++++++++
 1 files changed

// File: rtl/icache_refill_engine.sv
// icache_refill_engine: fetches one cache block from memory and delivers it to the I-cache as word pairs
module icache_refill_engine #(
    parameter int CACHE_BLOCK_SIZE = 64,
    parameter int PC_LENGTH        = 32,
    parameter int INST_LENGTH      = 32,
    localparam int NWORDS          = CACHE_BLOCK_SIZE / 4,
    localparam int WORD_OFFSET     = $clog2(NWORDS),
    localparam int AW              = WORD_OFFSET - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [PC_LENGTH-1:0]   miss_addr,
    input  logic                   flush,
    output logic                   refill_busy,
    output logic                   mem_req,
    output logic [PC_LENGTH-1:0]   mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INST_LENGTH-1:0] mem_rdata,
    output logic                   update,
    output logic [INST_LENGTH-1:0] w1_update,
    output logic [INST_LENGTH-1:0] w2_update,
    output logic [AW-1:0]          addr_update,
    output logic                   refill_done
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    localparam logic [WORD_OFFSET-1:0] LAST = WORD_OFFSET'(NWORDS - 1);
    localparam logic [PC_LENGTH-1:0]   OFFS = PC_LENGTH'(CACHE_BLOCK_SIZE - 1);

    state_t                 state_q, state_d;
    logic [WORD_OFFSET-1:0] cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic [INST_LENGTH-1:0] hold_q, hold_d;
    logic [PC_LENGTH-1:0]   addr_q, addr_d;
    logic                   upd_q, upd_d;
    logic [INST_LENGTH-1:0] w1_q, w1_d;
    logic [INST_LENGTH-1:0] w2_q, w2_d;
    logic [AW-1:0]          k_q, k_d;
    logic                   done_q, done_d;
    logic                   kill;

    // a flush arriving with a word already suppresses that word's pair
    assign kill        = drop_q | flush;
    assign mem_req     = state_q == REQ;
    assign refill_busy = state_q != IDLE;
    assign mem_addr    = addr_q;
    assign update      = upd_q;
    assign w1_update   = w1_q;
    assign w2_update   = w2_q;
    assign addr_update = k_q;
    assign refill_done = done_q;

    // next-state, word collection and pair packing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        upd_d   = 1'b0;
        w1_d    = w1_q;
        w2_d    = w2_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (miss_req) begin
                state_d = REQ;
                addr_d  = miss_addr & ~OFFS;
                cnt_d   = '0;
                drop_d  = 1'b0;
            end
            REQ: state_d = flush ? IDLE : mem_gnt ? FILL : REQ;
            FILL: begin
                drop_d = kill;
                if (mem_rvalid) begin
                    cnt_d = cnt_q + WORD_OFFSET'(1);
                    if (!cnt_q[0]) begin
                        hold_d = mem_rdata;
                    end else if (!kill) begin
                        upd_d = 1'b1;
                        w1_d  = hold_q;
                        w2_d  = mem_rdata;
                        k_d   = cnt_q[WORD_OFFSET-1:1];
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        done_d  = !kill;
                    end
                end
            end
            default: begin
                drop_d  = kill;
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            hold_q  <= '0;
            addr_q  <= '0;
            upd_q   <= 1'b0;
            w1_q    <= '0;
            w2_q    <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            upd_q   <= upd_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end
endmodule
